// File: rtl/axis_arb_pkg.sv
// Shared types and defaults for the packet-level AXI-stream character arbiter.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int DEFAULT_DATA_W    = 8;
  localparam int DEFAULT_TAG_DEPTH = 4;

  function automatic int idWidth(input int numReq);
    return $clog2(numReq);
  endfunction

endpackage

// File: rtl/axis_tag_fifo.sv
// Requester-ID FIFO: one entry per packet in flight inside the processor.
// Pointers carry an extra wrap bit so full and empty are distinguishable without a counter.
module axis_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wrPtr_q;
  logic [PTR_W:0]   rdPtr_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                   (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign doPop   = pop_i & ~empty_o;
  // A pop frees the head slot in the same cycle, so a push is still legal when full.
  assign doPush  = push_i & (~full_o | doPop);
  assign head_o  = mem_q[rdPtr_q[PTR_W-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/axis_char_arbiter.sv
// Round-robin packet arbiter sharing one AXI-stream character processor among requesters.
// Each granted packet's requester ID is queued so the processor's replies route back in order.
module axis_char_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int TAG_DEPTH = DEFAULT_TAG_DEPTH
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ*DATA_W-1:0]  s_tdata,
  input  logic [NUM_REQ-1:0]         s_tvalid,
  input  logic [NUM_REQ-1:0]         s_tlast,
  output logic [NUM_REQ-1:0]         s_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  input  logic                       m_tready,
  input  logic [DATA_W-1:0]          r_tdata,
  input  logic                       r_tvalid,
  input  logic                       r_tlast,
  output logic                       r_tready,
  output logic [DATA_W-1:0]          o_tdata,
  output logic                       o_tlast,
  output logic [NUM_REQ-1:0]         o_tvalid,
  input  logic [NUM_REQ-1:0]         o_tready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int ID_W = idWidth(NUM_REQ);

  arb_state_e      state_q;
  logic [ID_W-1:0] grantId_q;
  logic [ID_W-1:0] rrPtr_q;
  logic [ID_W-1:0] pickId_d;
  logic [ID_W-1:0] candId;
  logic [ID_W-1:0] nextPtr_d;
  logic            grantFire;
  logic            lastBeat;
  logic            tagFull;
  logic            tagEmpty;
  logic            tagPop;
  logic [ID_W-1:0] tagHead;

  // Walk from the highest offset down so the requester closest to rrPtr wins.
  always_comb begin
    pickId_d = rrPtr_q;
    candId   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      candId = ID_W'((int'(rrPtr_q) + k) % NUM_REQ);
      if (s_tvalid[candId]) pickId_d = candId;
    end
  end

  assign grantFire = (state_q == IDLE) && (|s_tvalid) && !tagFull;
  assign lastBeat  = (state_q == XFER) && m_tvalid && m_tready && m_tlast;
  assign nextPtr_d = (grantId_q == ID_W'(NUM_REQ - 1)) ? '0 : grantId_q + 1'b1;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      grantId_q <= '0;
      rrPtr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantFire) begin
            grantId_q <= pickId_d;
            state_q   <= XFER;
          end
        end
        XFER: begin
          if (lastBeat) begin
            rrPtr_q <= nextPtr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = s_tdata[grantId_q*DATA_W +: DATA_W];
    if (state_q == XFER) begin
      m_tvalid            = s_tvalid[grantId_q];
      m_tlast             = s_tlast[grantId_q];
      s_tready[grantId_q] = m_tready;
    end
  end

  // Replies belong to whichever requester sits at the tag FIFO head.
  always_comb begin
    o_tvalid = '0;
    r_tready = 1'b0;
    if (!tagEmpty) begin
      o_tvalid[tagHead] = r_tvalid;
      r_tready          = o_tready[tagHead];
    end
  end

  assign o_tdata  = r_tdata;
  assign o_tlast  = r_tlast;
  assign tagPop   = r_tvalid & r_tready & r_tlast;
  assign busy     = (state_q == XFER) | ~tagEmpty;
  assign grant_id = grantId_q;

  axis_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tagFifo (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .push_i  (grantFire),
    .data_i  (pickId_d),
    .pop_i   (tagPop),
    .full_o  (tagFull),
    .empty_o (tagEmpty),
    .head_o  (tagHead)
  );

endmodule

// File: tb/tb_axis_char_arbiter.sv
// Directed bench for axis_char_arbiter: arbitration order, tag backpressure, stalls and reset.
module tb_axis_char_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [7:0]  r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_tready;
  logic [7:0]  o_tdata;
  logic        o_tlast;
  logic [3:0]  o_tvalid;
  logic [3:0]  o_tready;
  logic [1:0]  grant_id;
  logic        busy;

  int numAsserts;
  int numFails;

  localparam logic [31:0] REQ_DATA = 32'h4443_4241;

  always #5 ap_clk = ~ap_clk;

  axis_char_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .TAG_DEPTH (4)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .r_tdata  (r_tdata),
    .r_tvalid (r_tvalid),
    .r_tlast  (r_tlast),
    .r_tready (r_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .grant_id (grant_id),
    .busy     (busy)
  );

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last,
                               input logic [31:0] data);
    s_tvalid = valid;
    s_tlast  = last;
    s_tdata  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numAsserts++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge ap_clk);
    #1;
  endtask

  // Holds reset for one negedge-to-negedge window, then lets one quiet edge pass.
  task automatic resetDut();
    applyStimulus(4'b0000, 4'b0000, REQ_DATA);
    m_tready = 1'b1;
    r_tvalid = 1'b0;
    r_tlast  = 1'b0;
    r_tdata  = 8'h00;
    o_tready = 4'b0000;
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    nextCycle();
  endtask

  initial begin
    numAsserts = 0;
    numFails   = 0;
    ap_rst_n   = 1'b0;
    m_tready   = 1'b1;
    r_tdata    = 8'h00;
    r_tlast    = 1'b0;
    applyStimulus(4'b1111, 4'b1111, REQ_DATA);
    r_tvalid   = 1'b1;
    o_tready   = 4'b1111;

    $display("[TB] reset state");
    #12;
    @(negedge ap_clk);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst s_tready", s_tready, 0);
    checkOutput("rst m_tvalid", m_tvalid, 0);
    checkOutput("rst m_tlast", m_tlast, 0);
    checkOutput("rst r_tready", r_tready, 0);
    checkOutput("rst o_tvalid", o_tvalid, 0);
    checkOutput("rst grant_id", grant_id, 0);

    $display("[TB] single requester round trip");
    resetDut();
    applyStimulus(4'b0001, 4'b0001, 32'h4443_4268);
    @(negedge ap_clk);
    checkOutput("t1 idle m_tvalid", m_tvalid, 0);
    nextCycle();
    @(negedge ap_clk);
    checkOutput("t1 m_tvalid", m_tvalid, 1);
    checkOutput("t1 m_tdata", m_tdata, 8'h68);
    checkOutput("t1 m_tlast", m_tlast, 1);
    checkOutput("t1 s_tready", s_tready, 4'b0001);
    checkOutput("t1 busy xfer", busy, 1);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, REQ_DATA);
    r_tvalid = 1'b1;
    r_tdata  = 8'h48;
    r_tlast  = 1'b1;
    o_tready = 4'b0001;
    @(negedge ap_clk);
    checkOutput("t1 m_tvalid after", m_tvalid, 0);
    checkOutput("t1 o_tvalid", o_tvalid, 4'b0001);
    checkOutput("t1 o_tdata", o_tdata, 8'h48);
    checkOutput("t1 r_tready", r_tready, 1);
    checkOutput("t1 busy pending", busy, 1);
    nextCycle();
    r_tvalid = 1'b0;
    r_tlast  = 1'b0;
    @(negedge ap_clk);
    checkOutput("t1 busy done", busy, 0);
    checkOutput("t1 o_tvalid done", o_tvalid, 0);

    $display("[TB] fairness with four continuous requesters");
    resetDut();
    r_tvalid = 1'b1;
    r_tlast  = 1'b1;
    o_tready = 4'b1111;
    applyStimulus(4'b1111, 4'b0000, REQ_DATA);
    for (int p = 0; p < 5; p++) begin
      s_tlast = 4'b0000;
      @(negedge ap_clk);
      checkOutput("fair idle m_tvalid", m_tvalid, 0);
      checkOutput("fair idle s_tready", s_tready, 0);
      nextCycle();
      @(negedge ap_clk);
      checkOutput("fair grant_id", grant_id, p % 4);
      checkOutput("fair beat0 s_tready", s_tready, 32'd1 << (p % 4));
      checkOutput("fair beat0 m_tdata", m_tdata, 8'h41 + (p % 4));
      checkOutput("fair beat0 m_tlast", m_tlast, 0);
      nextCycle();
      s_tlast = 4'(1 << (p % 4));
      @(negedge ap_clk);
      checkOutput("fair beat1 m_tvalid", m_tvalid, 1);
      checkOutput("fair beat1 m_tlast", m_tlast, 1);
      nextCycle();
    end

    $display("[TB] tag FIFO full backpressure");
    resetDut();
    applyStimulus(4'b0010, 4'b0010, REQ_DATA);
    for (int p = 0; p < 4; p++) begin
      @(negedge ap_clk);
      checkOutput("full idle m_tvalid", m_tvalid, 0);
      nextCycle();
      @(negedge ap_clk);
      checkOutput("full grant_id", grant_id, 1);
      checkOutput("full m_tvalid", m_tvalid, 1);
      checkOutput("full s_tready", s_tready, 4'b0010);
      nextCycle();
    end
    @(negedge ap_clk);
    checkOutput("full blocked m_tvalid", m_tvalid, 0);
    checkOutput("full busy", busy, 1);
    nextCycle();
    r_tvalid = 1'b1;
    r_tlast  = 1'b1;
    r_tdata  = 8'h21;
    o_tready = 4'b0010;
    @(negedge ap_clk);
    checkOutput("full pop m_tvalid", m_tvalid, 0);
    checkOutput("full pop r_tready", r_tready, 1);
    checkOutput("full pop o_tvalid", o_tvalid, 4'b0010);
    nextCycle();
    r_tvalid = 1'b0;
    r_tlast  = 1'b0;
    @(negedge ap_clk);
    checkOutput("full regrant idle", m_tvalid, 0);
    nextCycle();
    @(negedge ap_clk);
    checkOutput("full fifth m_tvalid", m_tvalid, 1);
    checkOutput("full fifth grant_id", grant_id, 1);

    $display("[TB] stall mid-packet");
    resetDut();
    applyStimulus(4'b0100, 4'b0000, REQ_DATA);
    @(negedge ap_clk);
    checkOutput("stall idle m_tvalid", m_tvalid, 0);
    nextCycle();
    @(negedge ap_clk);
    checkOutput("stall grant_id", grant_id, 2);
    checkOutput("stall beat0 m_tvalid", m_tvalid, 1);
    checkOutput("stall beat0 m_tdata", m_tdata, 8'h43);
    checkOutput("stall beat0 s_tready", s_tready, 4'b0100);
    nextCycle();
    applyStimulus(4'b0010, 4'b0010, REQ_DATA);
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      checkOutput("stall gap m_tvalid", m_tvalid, 0);
      checkOutput("stall gap m_tlast", m_tlast, 0);
      checkOutput("stall gap s_tready", s_tready, 4'b0100);
      checkOutput("stall gap grant_id", grant_id, 2);
      nextCycle();
    end
    applyStimulus(4'b0110, 4'b0110, REQ_DATA);
    @(negedge ap_clk);
    checkOutput("stall last m_tvalid", m_tvalid, 1);
    checkOutput("stall last m_tlast", m_tlast, 1);
    checkOutput("stall last m_tdata", m_tdata, 8'h43);
    checkOutput("stall last s_tready", s_tready, 4'b0100);
    nextCycle();
    applyStimulus(4'b0010, 4'b0010, REQ_DATA);
    @(negedge ap_clk);
    checkOutput("stall next idle", m_tvalid, 0);
    nextCycle();
    @(negedge ap_clk);
    checkOutput("stall next grant_id", grant_id, 1);
    checkOutput("stall next s_tready", s_tready, 4'b0010);
    checkOutput("stall next m_tdata", m_tdata, 8'h42);

    $display("[TB] return backpressure");
    resetDut();
    applyStimulus(4'b1000, 4'b1000, REQ_DATA);
    @(negedge ap_clk);
    nextCycle();
    @(negedge ap_clk);
    checkOutput("ret grant_id", grant_id, 3);
    checkOutput("ret m_tdata", m_tdata, 8'h44);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, REQ_DATA);
    r_tvalid = 1'b1;
    r_tdata  = 8'h5A;
    r_tlast  = 1'b1;
    o_tready = 4'b0111;
    for (int i = 0; i < 2; i++) begin
      @(negedge ap_clk);
      checkOutput("ret hold r_tready", r_tready, 0);
      checkOutput("ret hold o_tvalid", o_tvalid, 4'b1000);
      checkOutput("ret hold o_tdata", o_tdata, 8'h5A);
      checkOutput("ret hold busy", busy, 1);
      nextCycle();
    end
    o_tready = 4'b1111;
    @(negedge ap_clk);
    checkOutput("ret release r_tready", r_tready, 1);
    nextCycle();
    r_tvalid = 1'b0;
    r_tlast  = 1'b0;
    @(negedge ap_clk);
    checkOutput("ret busy done", busy, 0);
    checkOutput("ret o_tvalid done", o_tvalid, 0);

    $display("[TB] async reset during transfer");
    resetDut();
    applyStimulus(4'b0100, 4'b0100, REQ_DATA);
    nextCycle();
    @(negedge ap_clk);
    checkOutput("arst pre grant_id", grant_id, 2);
    nextCycle();
    applyStimulus(4'b1111, 4'b0000, REQ_DATA);
    r_tvalid = 1'b1;
    r_tlast  = 1'b0;
    o_tready = 4'b1111;
    @(negedge ap_clk);
    checkOutput("arst idle m_tvalid", m_tvalid, 0);
    nextCycle();
    @(negedge ap_clk);
    checkOutput("arst xfer grant_id", grant_id, 3);
    checkOutput("arst xfer m_tvalid", m_tvalid, 1);
    checkOutput("arst xfer m_tdata", m_tdata, 8'h44);
    checkOutput("arst xfer r_tready", r_tready, 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    checkOutput("arst m_tvalid", m_tvalid, 0);
    checkOutput("arst m_tlast", m_tlast, 0);
    checkOutput("arst s_tready", s_tready, 0);
    checkOutput("arst r_tready", r_tready, 0);
    checkOutput("arst o_tvalid", o_tvalid, 0);
    checkOutput("arst busy", busy, 0);
    checkOutput("arst grant_id", grant_id, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    nextCycle();
    @(negedge ap_clk);
    checkOutput("arst after grant_id", grant_id, 0);
    checkOutput("arst after m_tvalid", m_tvalid, 1);
    checkOutput("arst after m_tdata", m_tdata, 8'h41);
    checkOutput("arst after s_tready", s_tready, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule

// File: doc/axis_char_arbiter.md
# axis_char_arbiter

Packet-level round-robin arbiter that shares one HLS AXI-stream character processor (8-bit `input_r`/`output_r` streams) between several requesters. Each granted input packet is held until its TLAST beat. The requester ID is queued so that the processor's output packets are routed back, in order, to the requester that sent them. The block sits between the requester streams and the processor in the block design.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, stream data width (ASCII byte)
- TAG_DEPTH, 4, max packets in flight inside the processor (power of 2)

Ports:
- ap_clk  in  1  single clock; all logic rising-edge
- ap_rst_n  in  1  reset; asynchronous assert, active-low
- s_tdata  in  NUM_REQ*DATA_W  requester data, requester i at bits [i*DATA_W +: DATA_W]
- s_tvalid / s_tlast  in  NUM_REQ  per-requester valid / last
- s_tready  out  NUM_REQ  per-requester ready
- m_tdata  out  DATA_W  to processor input_r_TDATA
- m_tvalid, m_tlast  out  1  to processor input_r_TVALID / TLAST
- m_tready  in  1  from processor input_r_TREADY
- r_tdata  in  DATA_W  from processor output_r_TDATA
- r_tvalid, r_tlast  in  1  from processor output_r_TVALID / TLAST
- r_tready  out  1  to processor output_r_TREADY
- o_tdata  out  DATA_W  return data, shared bus to all requesters
- o_tlast  out  1  return last
- o_tvalid  out  NUM_REQ  one-hot return valid
- o_tready  in  NUM_REQ  per-requester return ready
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester
- busy  out  1  high in XFER or while the tag FIFO is non-empty

## Operation
- FSM has two states: IDLE and XFER.
- IDLE:
  - When any s_tvalid is high and the tag FIFO is not full, pick the first requester with tvalid high.
  - Search order is rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Register the choice into grant_id, push it into the tag FIFO, then go to XFER.
  - All s_tready and m_tvalid are low in IDLE.
- XFER (combinational pass-through for the granted requester g):
  - m_tdata = s_tdata[g], m_tvalid = s_tvalid[g], m_tlast = s_tlast[g], s_tready[g] = m_tready; all other s_tready are 0.
  - On m_tvalid & m_tready & m_tlast, return to IDLE and set rr_ptr = (g+1) mod NUM_REQ.
  - The grant is held regardless of s_tvalid gaps; there is no timeout.
- Return path: let h be the tag FIFO head.
  - o_tdata = r_tdata, o_tlast = r_tlast.
  - o_tvalid = r_tvalid one-hot at bit h.
  - r_tready = o_tready[h].
  - When the FIFO is empty: r_tready = 0 and o_tvalid = 0.
  - Pop on r_tvalid & r_tready & r_tlast.
- The processor preserves packet order and maps exactly one output packet to one input packet; the routing relies on this.

## Timing
- Reset (async, ap_rst_n low): FSM = IDLE, rr_ptr = 0, grant_id = 0, tag FIFO empty.
- Outputs during reset: busy = 0, and every s_tready, m_tvalid, m_tlast, r_tready, o_tvalid is 0. m_tdata and o_tdata are don't-care.
- Reset mid-packet: any partial packet is abandoned and outstanding tags are discarded. Upstream must also reset the processor.
- Arbitration latency: s_tvalid seen in IDLE at cycle n gives first m_tvalid at cycle n+1.
  - There is one idle cycle between back-to-back packets: TLAST handshake at cycle k, next grant decided at k+1, next first beat at k+2.
- Pass-through paths (s→m, r→o) have zero latency and no registers. Ready/valid follow AXI-stream: data holds until handshake.
- Tag FIFO full (TAG_DEPTH tags): no new grant. The FSM stays in IDLE until a pop.
- Push and pop in the same cycle are both allowed at any occupancy, including full. Occupancy then stays the same.
- Single-beat packet (tvalid & tlast on the first beat): one XFER cycle, provided m_tready = 1.
- Only one requester valid: it is granted every arbitration cycle, whatever rr_ptr is.

## Structure
- Package axis_arb_pkg holds:
  - the state enum (IDLE, XFER);
  - `ID_W = $clog2(NUM_REQ)` (as a function or localparam helper);
  - the default DATA_W and TAG_DEPTH constants.
- One sub-module, axis_tag_fifo:
  - synchronous FIFO, width ID_W, depth TAG_DEPTH;
  - ports: push/pop, full/empty, head;
  - pointers carry an extra wrap bit;
  - same async active-low reset.
- The top level contains the FSM, the round-robin search, and the mux/demux.

## Test plan
- Single requester: requester 0 sends 'h' (0x68) with tlast, processor echoes 0x48. Required: m_tdata = 0x68 one cycle after s_tvalid; output appears with o_tvalid = 4'b0001; busy falls after the return TLAST.
- Fairness: all 4 requesters hold 2-beat packets continuously. Grant order is 0,1,2,3,0; each packet takes 3 cycles (2 beats plus 1 arbitration cycle).
- Tag-full backpressure: TAG_DEPTH = 4, processor holds r_tvalid low, 5 packets are offered. Four are granted and the fifth waits in IDLE. One return TLAST pop then allows the fifth grant on the next cycle.
- Stall mid-packet: requester 2 drops s_tvalid for 5 cycles mid-packet while requester 1 is valid. The grant stays at 2, requester 1 sees s_tready = 0 throughout, and m_tlast appears only from requester 2.
- Return backpressure: the head tag is 3 and o_tready[3] = 0. Then r_tready = 0, r_tdata is held, and the other o_tvalid bits stay 0.
- Async reset during XFER: ap_rst_n goes low mid-cycle. All outputs drop to 0 immediately. After release, the first grant goes to requester 0 when several requesters are valid.
